// File: rtl/dffram_bus_adapter.sv
// Valid/ready front end for a 4096x32 DFFRAM.
// Byte-addressed requests go to the RAM port in the cycle they are accepted.
// The 1-cycle read latency is absorbed by a one-entry stage register.
// In-order responses wait in a small FIFO, so the consumer may stall without losing data.
module dffram_bus_adapter #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned RSP_DEPTH = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [31:0]       req_addr_i,
    input  logic [3:0]        req_be_i,
    input  logic [31:0]       req_wdata_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [31:0]       rsp_rdata_o,
    output logic              rsp_err_o,
    output logic              ram_en_o,
    output logic [3:0]        ram_we_o,
    output logic [31:0]       ram_di_o,
    output logic [ADDR_W-1:0] ram_a_o,
    input  logic [31:0]       ram_do_i
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(RSP_DEPTH);

    // Outstanding responses: stage-1 entry plus FIFO entries.
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;

    // Stage-1 register: tracks the request whose RAM read data arrives this cycle.
    logic             s1_valid;
    logic             s1_we;
    logic             s1_err;

    // Response FIFO storage and pointers.
    logic [31:0]      fifo_rdata [RSP_DEPTH];
    logic             fifo_err   [RSP_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fill;
    logic [CNT_W-1:0] fill_nxt;

    logic             accept;
    logic             req_err;
    logic             push;
    logic             pop;
    logic             fifo_empty;
    logic [31:0]      push_rdata;

    // Request side: acceptance, address checking and the RAM port drive.
    always_comb begin
        req_ready_o = 1'b0;
        accept      = 1'b0;
        req_err     = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 4'b0;
        req_ready_o = rst_ni & (count < CNT_W'(RSP_DEPTH));
        accept      = req_valid_i & req_ready_o;
        req_err     = (req_addr_i[1:0] != 2'b00) |
                      (req_addr_i[31:ADDR_W+2] != '0);
        ram_en_o    = accept & ~req_err;
        ram_we_o    = (ram_en_o & req_we_i) ? req_be_i : 4'b0;
        ram_a_o     = req_addr_i[ADDR_W+1:2];
        ram_di_o    = req_wdata_i;
    end

    // Response side: FIFO head, push/pop and the next values of the counters.
    always_comb begin
        fifo_empty  = (fill == '0);
        rsp_valid_o = rst_ni & ~fifo_empty;
        pop         = rsp_valid_o & rsp_ready_i;
        push        = s1_valid;
        push_rdata  = (s1_valid & ~s1_we & ~s1_err) ? ram_do_i : 32'h0;
        rsp_rdata_o = rsp_valid_o ? fifo_rdata[rd_ptr] : 32'h0;
        rsp_err_o   = rsp_valid_o ? fifo_err[rd_ptr] : 1'b0;
        count_nxt   = count + CNT_W'(accept) - CNT_W'(pop);
        fill_nxt    = fill + CNT_W'(push) - CNT_W'(pop);
    end

    // Control state: outstanding count, stage-1 tracking and FIFO pointers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count    <= '0;
            s1_valid <= 1'b0;
            s1_we    <= 1'b0;
            s1_err   <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fill     <= '0;
        end else begin
            count    <= count_nxt;
            s1_valid <= accept;
            s1_we    <= req_we_i;
            s1_err   <= req_err;
            fill     <= fill_nxt;
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
        end
    end

    // FIFO payload storage; it is never reset because the fill level guards reads.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            fifo_rdata[wr_ptr] <= push_rdata;
            fifo_err[wr_ptr]   <= s1_err;
        end
    end

    // The outstanding count bounds the FIFO, so a push into a full FIFO indicates a design bug.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push && !pop && (fill == CNT_W'(RSP_DEPTH))));

endmodule

// File: tb/tb_dffram_bus_adapter.sv
// Directed bench for dffram_bus_adapter with a behavioural DFFRAM model attached.
module tb_dffram_bus_adapter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [3:0]  req_be_i;
    logic [31:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        ram_en_o;
    logic [3:0]  ram_we_o;
    logic [31:0] ram_di_o;
    logic [11:0] ram_a_o;
    logic [31:0] ram_do_i;

    int total = 0;
    int bad   = 0;
    int acc;

    logic [31:0] mem [0:4095];

    dffram_bus_adapter #(.ADDR_W(12), .RSP_DEPTH(3)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i),
        .req_be_i(req_be_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_di_o(ram_di_o), .ram_a_o(ram_a_o), .ram_do_i(ram_do_i)
    );

    always #5 clk_i = ~clk_i;

    // DFFRAM model: byte-masked write, registered read of the old contents.
    always @(posedge clk_i) begin
        if (ram_en_o) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_we_o[b]) mem[ram_a_o][8*b +: 8] <= ram_di_o[8*b +: 8];
            end
            ram_do_i <= mem[ram_a_o];
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
        req_valid_i = v;
        req_we_i    = we;
        req_addr_i  = a;
        req_be_i    = be;
        req_wdata_i = wd;
    endtask

    initial begin
        rst_ni      = 1'b0;
        rsp_ready_i = 1'b1;
        ram_do_i    = 32'h0;
        drive(1'b1, 1'b1, 32'h10, 4'hF, 32'h0BAD_0BAD);

        // Reset: nothing accepted, nothing issued to the RAM
        tick();
        settle();
        chk("rst_req_ready", 32'(req_ready_o), 32'h0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("rst_ram_en",    32'(ram_en_o),    32'h0);
        chk("rst_ram_we",    32'(ram_we_o),    32'h0);
        chk("rst_rdata",     rsp_rdata_o,      32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_ni = 1'b1;
        settle();
        chk("post_rst_ready", 32'(req_ready_o), 32'h1);

        // Full write followed by a read of the same word
        drive(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
        settle();
        chk("w1_ram_en", 32'(ram_en_o), 32'h1);
        chk("w1_ram_we", 32'(ram_we_o), 32'hF);
        chk("w1_ram_a",  32'(ram_a_o),  32'h4);
        chk("w1_ram_di", ram_di_o,      32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
        settle();
        chk("r1_ram_en",    32'(ram_en_o),    32'h1);
        chk("r1_ram_we",    32'(ram_we_o),    32'h0);
        chk("r1_ram_a",     32'(ram_a_o),     32'h4);
        chk("r1_rsp_early", 32'(rsp_valid_o), 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("w1_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("w1_rsp_rdata", rsp_rdata_o,      32'h0);
        chk("w1_rsp_err",   32'(rsp_err_o),   32'h0);
        tick();
        settle();
        chk("r1_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("r1_rsp_rdata", rsp_rdata_o,      32'hDEAD_BEEF);
        chk("r1_rsp_err",   32'(rsp_err_o),   32'h0);
        tick();
        settle();
        chk("r1_drained", 32'(rsp_valid_o), 32'h0);

        // Partial write merges bytes 0 and 2
        drive(1'b1, 1'b1, 32'h10, 4'b0101, 32'h1122_3344);
        settle();
        chk("w2_ram_we", 32'(ram_we_o), 32'h5);
        tick();
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("w2_rsp_rdata", rsp_rdata_o, 32'h0);
        tick();
        settle();
        chk("r2_rsp_rdata", rsp_rdata_o, 32'hDE22_BE44);
        tick();

        // Misaligned and out-of-range reads between two good reads
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        settle();
        chk("e0_ram_en", 32'(ram_en_o), 32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h2, 4'h0, 32'h0);
        settle();
        chk("e1_ram_en", 32'(ram_en_o), 32'h0);
        chk("e1_ready",  32'(req_ready_o), 32'h1);
        tick();
        drive(1'b1, 1'b0, 32'h4000, 4'hF, 32'h0);
        settle();
        chk("e2_ram_en", 32'(ram_en_o), 32'h0);
        chk("e2_ram_we", 32'(ram_we_o), 32'h0);
        chk("e0_rsp_rdata", rsp_rdata_o,    32'hDE22_BE44);
        chk("e0_rsp_err",   32'(rsp_err_o), 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        settle();
        chk("e3_ram_en",    32'(ram_en_o),    32'h1);
        chk("e1_rsp_valid", 32'(rsp_valid_o), 32'h1);
        chk("e1_rsp_err",   32'(rsp_err_o),   32'h1);
        chk("e1_rsp_rdata", rsp_rdata_o,      32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("e2_rsp_err",   32'(rsp_err_o), 32'h1);
        chk("e2_rsp_rdata", rsp_rdata_o,    32'h0);
        tick();
        settle();
        chk("e3_rsp_err",   32'(rsp_err_o), 32'h0);
        chk("e3_rsp_rdata", rsp_rdata_o,    32'hDE22_BE44);
        tick();

        // Eight back-to-back writes, then eight back-to-back reads
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b1, 32'h100 + 32'(4 * i), 4'hF, 32'hA500_0000 + 32'(i));
            else       drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            settle();
            if (i < 8) chk("bw_ready", 32'(req_ready_o), 32'h1);
            if (i >= 2) begin
                chk("bw_rsp_valid", 32'(rsp_valid_o), 32'h1);
                chk("bw_rsp_rdata", rsp_rdata_o,      32'h0);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) begin
            if (i < 8) drive(1'b1, 1'b0, 32'h100 + 32'(4 * i), 4'h0, 32'h0);
            else       drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
            settle();
            if (i < 8) chk("br_ready", 32'(req_ready_o), 32'h1);
            if (i < 2) chk("br_rsp_early", 32'(rsp_valid_o), 32'h0);
            else begin
                chk("br_rsp_valid", 32'(rsp_valid_o), 32'h1);
                chk("br_rsp_rdata", rsp_rdata_o,      32'hA500_0000 + 32'(i - 2));
            end
            tick();
        end

        // Stalled consumer: exactly three requests fit
        rsp_ready_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 32'h100 + 32'(4 * acc), 4'h0, 32'h0);
            settle();
            if (req_ready_o) acc++;
            tick();
        end
        chk("stall_accepted", 32'(acc), 32'h3);
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        settle();
        chk("stall_ready", 32'(req_ready_o), 32'h0);
        rsp_ready_i = 1'b1;
        settle();
        chk("rel0_rdata", rsp_rdata_o,      32'hA500_0000);
        chk("rel0_ready", 32'(req_ready_o), 32'h0);
        tick();
        settle();
        chk("rel1_rdata", rsp_rdata_o,      32'hA500_0001);
        chk("rel1_ready", 32'(req_ready_o), 32'h1);
        tick();
        settle();
        chk("rel2_rdata", rsp_rdata_o,      32'hA500_0002);
        tick();
        settle();
        chk("rel_drained", 32'(rsp_valid_o), 32'h0);

        // Reset with two responses buffered drops them
        rsp_ready_i = 1'b0;
        drive(1'b1, 1'b0, 32'h104, 4'h0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 32'h108, 4'h0, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        settle();
        chk("pre_rst_valid", 32'(rsp_valid_o), 32'h1);
        chk("pre_rst_rdata", rsp_rdata_o,      32'hA500_0001);
        rst_ni = 1'b0;
        drive(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        settle();
        chk("mid_rst_valid", 32'(rsp_valid_o), 32'h0);
        chk("mid_rst_ready", 32'(req_ready_o), 32'h0);
        chk("mid_rst_ram_en", 32'(ram_en_o),   32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst_ni = 1'b1;
        rsp_ready_i = 1'b1;
        settle();
        chk("post_rst2_valid", 32'(rsp_valid_o), 32'h0);
        chk("post_rst2_ready", 32'(req_ready_o), 32'h1);
        tick();
        settle();
        chk("post_rst2_empty", 32'(rsp_valid_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
